// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned multiply/divide unit with architectural HI/LO registers.
// Retires STEP multiplier or quotient bits per cycle. Requests a stall while busy.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcAE,
  input  logic [WIDTH-1:0] srcBE,
  input  logic             hiloreadE,
  input  logic             hilowriteE,
  input  logic             lohiE,
  output logic [WIDTH-1:0] hiloout,
  output logic             busy,
  output logic             stallreq,
  output logic             done,
  output logic             divzero
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   op_a, op_b, a_orig;
  logic               is_div, neg_res, neg_rem, div_zero_op;
  logic [2*WIDTH-1:0] prod, prod_step, prod_fix;
  logic [WIDTH:0]     rem, rem_step, sum;
  logic [WIDTH-1:0]   quo, quo_step, quo_fix, rem_fix;
  logic               signed_op, a_sign, b_sign;
  logic [WIDTH-1:0]   a_abs, b_abs;

  assign signed_op = ~opE[0];
  assign a_sign    = signed_op & srcAE[WIDTH-1];
  assign b_sign    = signed_op & srcBE[WIDTH-1];
  assign a_abs     = a_sign ? -srcAE : srcAE;
  assign b_abs     = b_sign ? -srcBE : srcBE;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (startE) state_next = CALC;
      CALC:    if (count == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      divzero <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          // A simultaneous startE takes priority over mthi/mtlo.
          if (!startE && hilowriteE) begin
            if (lohiE) lo <= srcAE;
            else       hi <= srcAE;
          end
        end
        CALC: count <= count + 1'b1;
        FIX: begin
          done    <= 1'b1;
          divzero <= is_div & div_zero_op;
          if (is_div) begin
            if (div_zero_op) begin
              hi <= a_orig;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Operands are held as magnitudes; result signs are reapplied in FIX.
  always_ff @(posedge clk) begin
    if (state == IDLE && startE) begin
      is_div      <= opE[1];
      neg_res     <= a_sign ^ b_sign;
      neg_rem     <= a_sign;
      div_zero_op <= (srcBE == '0);
      a_orig      <= srcAE;
      op_a        <= a_abs;
      op_b        <= b_abs;
      prod        <= {{WIDTH{1'b0}}, b_abs};
      quo         <= a_abs;
      rem         <= '0;
    end else if (state == CALC) begin
      prod <= prod_step;
      rem  <= rem_step;
      quo  <= quo_step;
    end
  end

  always_comb begin
    prod_step = prod;
    rem_step  = rem;
    quo_step  = quo;
    sum       = '0;
    for (int i = 0; i < STEP; i++) begin
      if (is_div) begin
        rem_step = {rem_step[WIDTH-1:0], quo_step[WIDTH-1]};
        quo_step = {quo_step[WIDTH-2:0], 1'b0};
        if (rem_step >= {1'b0, op_b}) begin
          rem_step    = rem_step - {1'b0, op_b};
          quo_step[0] = 1'b1;
        end
      end else begin
        sum       = {1'b0, prod_step[2*WIDTH-1:WIDTH]} + (prod_step[0] ? {1'b0, op_a} : '0);
        prod_step = {sum, prod_step[WIDTH-1:1]};
      end
    end
  end

  assign prod_fix = neg_res ? -prod : prod;
  assign quo_fix  = neg_res ? -quo : quo;
  assign rem_fix  = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  assign busy     = (state != IDLE);
  assign stallreq = busy & (startE | hiloreadE | hilowriteE);
  assign hiloout  = lohiE ? lo : hi;

endmodule
